// File: rtl/hazard_scoreboard_pkg.sv
// Shared slot record for the EXE/MEM/WB shadow pipeline, plus the bubble and R0 constants.
package hazard_scoreboard_pkg;

  localparam int SLOT_AW = 5;

  typedef struct packed {
    logic [SLOT_AW-1:0] dest;
    logic               wb_en;
    logic               mem_read;
  } slot_t;

  localparam slot_t BUBBLE = '0;
  localparam logic [SLOT_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/hazard_src_match.sv
// Compares one source register against the EXE/MEM/WB slots; hit_o = {wb, mem, exe}.
// Purely combinational, no backpressure.
module hazard_src_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW = SLOT_AW
) (
  input  logic [REG_AW-1:0] src_i,
  input  slot_t             exe_i,
  input  slot_t             mem_i,
  input  slot_t             wb_i,
  output logic [2:0]        hit_o
);

  logic src_nz;
  logic unused_mem_read;

  // R0 is hardwired, so it can never be a real dependency.
  assign src_nz = (src_i != REG_ZERO);

  assign hit_o[0] = src_nz & exe_i.wb_en & (exe_i.dest == src_i);
  assign hit_o[1] = src_nz & mem_i.wb_en & (mem_i.dest == src_i);
  assign hit_o[2] = src_nz & wb_i.wb_en  & (wb_i.dest  == src_i);

  assign unused_mem_read = ^{exe_i.mem_read, mem_i.mem_read, wb_i.mem_read};

endmodule

// File: rtl/hazard_scoreboard.sv
// Shadow EXE/MEM/WB slots feeding forwarding; raises hazard_stall combinationally, slots advance 1/clk.
// mem_stall freezes all slots; HAZARD_STATS_EN builds a saturating stall-cycle counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_AW = SLOT_AW,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic [REG_AW-1:0] id_src3,
  input  logic              id_uses_src2,
  input  logic              id_is_store_bne,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_read,
  input  logic              forwarding_enable,
  input  logic              mem_stall,
  input  logic              flush,
  output logic              hazard_stall,
  output logic [REG_AW-1:0] exe_dest,
  output logic              exe_wb_en,
  output logic [REG_AW-1:0] mem_dest,
  output logic              mem_wb_en,
  output logic [REG_AW-1:0] wb_dest,
  output logic              wb_wb_en,
  output logic [STAT_W-1:0] stall_cycles
);

  slot_t exe_q, exe_d;
  slot_t mem_q, mem_d;
  slot_t wb_q,  wb_d;
  slot_t id_slot;

  logic [2:0] hit1, hit2, hit3;
  logic       exe_hit, mem_hit, stall_raw;
  logic       unused_bits;

  hazard_src_match #(.REG_AW(REG_AW)) u_match_src1 (
    .src_i(id_src1), .exe_i(exe_q), .mem_i(mem_q), .wb_i(wb_q), .hit_o(hit1)
  );
  hazard_src_match #(.REG_AW(REG_AW)) u_match_src2 (
    .src_i(id_src2), .exe_i(exe_q), .mem_i(mem_q), .wb_i(wb_q), .hit_o(hit2)
  );
  hazard_src_match #(.REG_AW(REG_AW)) u_match_src3 (
    .src_i(id_src3), .exe_i(exe_q), .mem_i(mem_q), .wb_i(wb_q), .hit_o(hit3)
  );

  assign exe_hit = hit1[0] | (id_uses_src2 & hit2[0]) | (id_is_store_bne & hit3[0]);
  assign mem_hit = hit1[1] | (id_uses_src2 & hit2[1]) | (id_is_store_bne & hit3[1]);

  // WB matches never stall: the register file writes before it reads.
  assign unused_bits = ^{hit1[2], hit2[2], hit3[2], mem_q.mem_read, wb_q.mem_read};

  assign stall_raw = forwarding_enable ? (exe_q.mem_read & exe_hit) : (exe_hit | mem_hit);
  assign hazard_stall = id_valid & ~flush & stall_raw;

  assign id_slot = '{dest: id_dest, wb_en: id_wb_en, mem_read: id_mem_read};

  always_comb begin
    exe_d = exe_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!mem_stall) begin
      wb_d  = mem_q;
      mem_d = exe_q;
      exe_d = (id_valid && !hazard_stall && !flush) ? id_slot : BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q <= BUBBLE;
      mem_q <= BUBBLE;
      wb_q  <= BUBBLE;
    end else begin
      exe_q <= exe_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign exe_dest  = exe_q.dest;
  assign exe_wb_en = exe_q.wb_en;
  assign mem_dest  = mem_q.dest;
  assign mem_wb_en = mem_q.wb_en;
  assign wb_dest   = wb_q.dest;
  assign wb_wb_en  = wb_q.wb_en;

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard_stall && !mem_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: a reference pipeline model pushes expected results each cycle.
module tb_hazard_scoreboard;

  localparam int AW = 5;
  localparam int SW = 4;
  localparam int CNT_MAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_src1 = '0, id_src2 = '0, id_src3 = '0, id_dest = '0;
  logic          id_uses_src2 = 1'b0, id_is_store_bne = 1'b0;
  logic          id_wb_en = 1'b0, id_mem_read = 1'b0;
  logic          forwarding_enable = 1'b1, mem_stall = 1'b0, flush = 1'b0;
  logic          hazard_stall;
  logic [AW-1:0] exe_dest, mem_dest, wb_dest;
  logic          exe_wb_en, mem_wb_en, wb_wb_en;
  logic [SW-1:0] stall_cycles;

  hazard_scoreboard #(.REG_AW(AW), .STAT_W(SW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_src3(id_src3),
    .id_uses_src2(id_uses_src2), .id_is_store_bne(id_is_store_bne),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .forwarding_enable(forwarding_enable), .mem_stall(mem_stall), .flush(flush),
    .hazard_stall(hazard_stall),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
    .wb_dest(wb_dest), .wb_wb_en(wb_wb_en),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit stall;
    int exe_dest; bit exe_wb;
    int mem_dest; bit mem_wb;
    int wb_dest;  bit wb_wb;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference pipeline: index 0 = EXE, 1 = MEM, 2 = WB.
  bit [AW-1:0] m_dest[3];
  bit          m_wb[3];
  bit          m_mr[3];
  int          m_cnt = 0;

  bit c_fw = 1'b1, c_ms = 1'b0, c_fl = 1'b0, c_r = 1'b1;
  int stall_seen = 0;
  bit last_stall = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  function automatic bit model_stall();
    bit [AW-1:0] src[3];
    bit          used[3];
    bit          hz = 1'b0;
    src[0] = id_src1; src[1] = id_src2; src[2] = id_src3;
    used[0] = 1'b1; used[1] = id_uses_src2; used[2] = id_is_store_bne;
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 2; k++) begin
        if (used[s] && src[s] != 0 && m_wb[k] && m_dest[k] == src[s]) begin
          if (!forwarding_enable || (k == 0 && m_mr[0])) hz = 1'b1;
        end
      end
    end
    return hz && id_valid && !flush;
  endfunction

  task automatic cyc(input bit v, input int s1, input int s2, input int s3,
                     input bit u2, input bit sb, input int d, input bit we, input bit mr);
    exp_t e, got_e;
    bit   st;
    @(negedge clk);
    id_valid = v; id_src1 = AW'(s1); id_src2 = AW'(s2); id_src3 = AW'(s3);
    id_uses_src2 = u2; id_is_store_bne = sb;
    id_dest = AW'(d); id_wb_en = we; id_mem_read = mr;
    forwarding_enable = c_fw; mem_stall = c_ms; flush = c_fl; rst = c_r;
    #1;
    st = model_stall();
    if (c_r) begin
      for (int k = 0; k < 3; k++) begin m_dest[k] = '0; m_wb[k] = 1'b0; m_mr[k] = 1'b0; end
      m_cnt = 0;
    end else if (!c_ms) begin
`ifdef HAZARD_STATS_EN
      if (st && m_cnt != CNT_MAX) m_cnt++;
`endif
      for (int k = 2; k > 0; k--) begin
        m_dest[k] = m_dest[k-1]; m_wb[k] = m_wb[k-1]; m_mr[k] = m_mr[k-1];
      end
      if (v && !st && !c_fl) begin
        m_dest[0] = AW'(d); m_wb[0] = we; m_mr[0] = mr;
      end else begin
        m_dest[0] = '0; m_wb[0] = 1'b0; m_mr[0] = 1'b0;
      end
    end
    e.stall = st;
    e.exe_dest = int'(m_dest[0]); e.exe_wb = m_wb[0];
    e.mem_dest = int'(m_dest[1]); e.mem_wb = m_wb[1];
    e.wb_dest  = int'(m_dest[2]); e.wb_wb  = m_wb[2];
    e.cnt = m_cnt;
    exp_q.push_back(e);
    check("hazard_stall", hazard_stall, exp_q[0].stall);
    last_stall = hazard_stall;
    if (hazard_stall) stall_seen++;
    @(posedge clk);
    #1;
    got_e = exp_q.pop_front();
    check("exe_dest", exe_dest, got_e.exe_dest);
    check("exe_wb_en", exe_wb_en, got_e.exe_wb);
    check("mem_dest", mem_dest, got_e.mem_dest);
    check("mem_wb_en", mem_wb_en, got_e.mem_wb);
    check("wb_dest", wb_dest, got_e.wb_dest);
    check("wb_wb_en", wb_wb_en, got_e.wb_wb);
    check("stall_cycles", stall_cycles, got_e.cnt);
  endtask

  // Re-present the same ID instruction while the DUT stalls, as IF/ID would.
  task automatic issue(input int s1, input int s2, input int s3, input bit u2,
                       input bit sb, input int d, input bit we, input bit mr);
    int tries = 0;
    do begin
      cyc(1'b1, s1, s2, s3, u2, sb, d, we, mr);
      tries++;
    end while (last_stall && tries < 6);
    check("issue_bound", last_stall, 1'b0);
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin m_dest[k] = '0; m_wb[k] = 1'b0; m_mr[k] = 1'b0; end
    c_r = 1'b1;
    bubbles(2);
    c_r = 1'b0;
    check("rst_exe_wb_en", exe_wb_en, 1'b0);
    check("rst_stall_cycles", stall_cycles, 0);

    // Load-use with forwarding: one stall cycle.
    stall_seen = 0;
    issue(0, 0, 0, 1'b0, 1'b0, 3, 1'b1, 1'b1);
    issue(3, 0, 0, 1'b0, 1'b0, 6, 1'b1, 1'b0);
    check("lu_stalls", stall_seen, 1);
    check("lu_exe_dest", exe_dest, 6);
    check("lu_wb_dest", wb_dest, 3);
    bubbles(3);

    // Forwarding disabled: dependent right behind producer stalls two cycles.
    c_fw = 1'b0;
    stall_seen = 0;
    issue(0, 0, 0, 1'b0, 1'b0, 4, 1'b1, 1'b0);
    issue(7, 4, 0, 1'b1, 1'b0, 8, 1'b1, 1'b0);
    check("nf_stalls", stall_seen, 2);
    bubbles(3);

    // R0 and unused sources never stall; a used src3 does.
    stall_seen = 0;
    issue(0, 0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    issue(0, 0, 0, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    issue(0, 0, 0, 1'b0, 1'b0, 9, 1'b1, 1'b0);
    issue(2, 9, 9, 1'b0, 1'b0, 10, 1'b1, 1'b0);
    check("r0_unused_stalls", stall_seen, 0);
    issue(2, 0, 9, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    check("src3_stalls", stall_seen, 1);
    bubbles(3);

    // Freeze with a load in MEM and a stalled dependent in ID.
    c_fw = 1'b1;
    issue(0, 0, 0, 1'b0, 1'b0, 5, 1'b1, 1'b1);
    bubbles(1);
    c_fw = 1'b0; c_ms = 1'b1;
    stall_seen = 0;
    for (int i = 0; i < 3; i++) cyc(1'b1, 5, 0, 0, 1'b0, 1'b0, 14, 1'b1, 1'b0);
    check("frz_stalls", stall_seen, 3);
    check("frz_mem_dest", mem_dest, 5);
    check("frz_wb_wb_en", wb_wb_en, 1'b0);
    c_ms = 1'b0; c_fw = 1'b1;
    bubbles(3);

    // Flush squashes the ID instruction and masks its hazard.
    issue(0, 0, 0, 1'b0, 1'b0, 8, 1'b1, 1'b1);
    c_fl = 1'b1;
    cyc(1'b1, 8, 0, 0, 1'b0, 1'b0, 15, 1'b1, 1'b0);
    check("flush_stall", last_stall, 1'b0);
    check("flush_exe_wb_en", exe_wb_en, 1'b0);
    c_fl = 1'b0;
    bubbles(3);

    // Enough stall cycles to saturate the narrow counter.
    c_fw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      issue(0, 0, 0, 1'b0, 1'b0, 12, 1'b1, 1'b0);
      issue(12, 0, 0, 1'b0, 1'b0, 13, 1'b1, 1'b0);
    end
`ifdef HAZARD_STATS_EN
    check("sat_cnt", stall_cycles, CNT_MAX);
`else
    check("sat_cnt", stall_cycles, 0);
`endif

    // Random traffic over a small register set to provoke matches.
    for (int i = 0; i < 400; i++) begin
      c_fw = 1'($urandom_range(0, 1));
      c_ms = ($urandom_range(0, 4) == 0);
      c_fl = ($urandom_range(0, 9) == 0);
      c_r  = ($urandom_range(0, 49) == 0);
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset while frozen with every slot full.
    c_r = 1'b0; c_ms = 1'b0; c_fl = 1'b0; c_fw = 1'b1;
    issue(0, 0, 0, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    issue(0, 0, 0, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    issue(0, 0, 0, 1'b0, 1'b0, 3, 1'b1, 1'b0);
    c_ms = 1'b1; c_r = 1'b1;
    bubbles(1);
    check("mrst_exe_wb_en", exe_wb_en, 1'b0);
    check("mrst_mem_wb_en", mem_wb_en, 1'b0);
    check("mrst_wb_wb_en", wb_wb_en, 1'b0);
    check("mrst_stall_cycles", stall_cycles, 0);
    c_ms = 1'b0; c_r = 1'b0;
    bubbles(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Producer side of the operand-forwarding path. The block keeps a shadow copy of the destination, write-enable and memory-read flags for the in-flight EXE, MEM and WB instructions. It publishes the MEM and WB destination and enable signals that operand forwarding consumes. It also raises hazard_stall toward IF/ID when the decoding instruction cannot be served by forwarding: a load-use hazard, or any RAW hazard while forwarding is disabled.

Parameters:
REG_AW, 5, register-address width
STAT_W, 16, stall-counter width (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID stage holds a real instruction
id_src1  in  REG_AW  first source register
id_src2  in  REG_AW  second source register
id_src3  in  REG_AW  store-data / bne-compare register
id_uses_src2  in  1  src2 is read by this instruction
id_is_store_bne  in  1  src3 is read (store or bne)
id_dest  in  REG_AW  destination register
id_wb_en  in  1  instruction writes the register file
id_mem_read  in  1  instruction is a load
forwarding_enable  in  1  forwarding active
mem_stall  in  1  data memory busy; freezes EXE/MEM/WB
flush  in  1  taken branch; squash the ID instruction
hazard_stall  out  1  hold PC and IF/ID, inject bubble
exe_dest  out  REG_AW  EXE-slot destination
exe_wb_en  out  1  EXE-slot write enable
mem_dest  out  REG_AW  MEM-slot destination (to forwarding)
mem_wb_en  out  1  MEM-slot write enable
wb_dest  out  REG_AW  WB-slot destination (to forwarding)
wb_wb_en  out  1  WB-slot write enable
stall_cycles  out  STAT_W  hazard-stall cycle count

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous, active-high.
- Slot contents: three registered slots EXE, MEM and WB. Each slot holds {dest, wb_en, mem_read}.
- Bubble: {0, 0, 0}.
- Reset: all slots are bubbles. All outputs are 0, including stall_cycles.
- Advance rule: when mem_stall=0, on each clk edge WB<=MEM and MEM<=EXE.
- EXE load: EXE<=ID entry if id_valid & ~hazard_stall & ~flush; otherwise EXE<=bubble.
- Freeze: when mem_stall=1, all slots hold their values. Freeze takes priority over flush and hazard; upstream holds flush until the pipeline advances.
- Source usage: src1 is always used. src2 is used only if id_uses_src2. src3 is used only if id_is_store_bne.
- Slot match: slot X matches source s when X.wb_en=1 and X.dest==s and s!=0. R0 never hazards.
- Stall with forwarding_enable=1: stall if EXE.mem_read=1 and EXE matches any used source (load-use).
- Stall with forwarding_enable=0: stall if EXE or MEM matches any used source.
- WB never causes a stall: the register file writes before it reads.
- hazard_stall output: the combinational stall condition gated by id_valid & ~flush. It is independent of mem_stall.
- Outputs: exe_*, mem_* and wb_* are direct slot registers, so they have zero combinational depth toward the forwarding logic.
- Stall latency: a load in EXE with a dependent instruction in ID gives exactly one stall cycle (without mem_stall). After that, the load is in MEM and forwarding covers it.
- Forwarding-disabled latency: a dependent instruction directly behind a producer stalls 2 cycles.
- Mid-operation reset: slots clear on the next edge regardless of mem_stall or flush.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: stall_cycles increments on every clk edge where hazard_stall=1 and mem_stall=0. It saturates at all-ones and clears on rst.
- Undefined: no counter is built, and stall_cycles is tied to 0.

Decomposition:
- Shared package: the slot struct typedef {dest, wb_en, mem_read}, the BUBBLE constant, and the REG_ZERO constant.
- One natural sub-module, hazard_src_match: compares one source against the three slots and returns per-slot match bits. It is instantiated three times (src1, src2, src3).

Test Plan:
- Load-use: cycle0 ID load R3 (mem_read=1, wb_en=1); cycle1 ID add src1=R3, fwd=1 -> hazard_stall=1 for 1 cycle, EXE bubble. Next cycle mem_dest=3, mem_wb_en=1, and the add enters EXE.
- No forwarding: add R4; next instruction uses src2=R4 with id_uses_src2=1, fwd=0 -> hazard_stall=1 for 2 cycles, then 0 once the producer reaches WB (wb_dest=4).
- R0 and unused sources: producer dest=0, or a match only on src3 with id_is_store_bne=0 -> hazard_stall stays 0.
- mem_stall freeze: assert mem_stall for 3 cycles while load R5 is in MEM -> mem_dest=5 and wb_dest are held constant. stall_cycles is not incremented during the freeze (with HAZARD_STATS_EN).
- Flush: flush=1 with id_valid=1 and a pending hazard -> hazard_stall=0, and EXE becomes a bubble (exe_wb_en=0) next cycle.
- Reset mid-stream: rst asserted during mem_stall with all slots full -> all *_wb_en=0 and stall_cycles=0 on the next edge.
